// File: rtl/mmu_tlb_pkg.sv
// mmu_pkg: shared definitions for the mmu_tlb address translator.
//   - EntryHi/EntryLo field positions
//   - cache attribute and segment codes
//   - tlb_entry_t: one stored TLB entry (ASID held zero-extended to 8 bits)
//   - xlate_t / translate(): segment decode plus even/odd page resolution
package mmu_pkg;

   localparam int VPN2_HI   = 31;
   localparam int VPN2_LO   = 13;
   localparam int LO_PFN_HI = 25;
   localparam int LO_PFN_LO = 6;
   localparam int LO_C_HI   = 5;
   localparam int LO_C_LO   = 3;
   localparam int LO_D      = 2;
   localparam int LO_V      = 1;
   localparam int LO_G      = 0;

   localparam logic [2:0] CACHE_UNCACHED = 3'd2;
   localparam logic [2:0] KSEG0          = 3'b100;
   localparam logic [2:0] KSEG1          = 3'b101;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic        present;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [31:0] paddr;
      logic        uncached;
      logic        miss;
      logic        invalid;
      logic        modified;
   } xlate_t;

   // Full translation of one access. 'e' is the lowest-index matching entry
   // and is only meaningful when 'hit' is set. Exceptions are mutually
   // exclusive (miss > invalid > modified) and force paddr/uncached to 0.
   function automatic xlate_t translate(input logic [31:0] va,
                                        input logic        hit,
                                        input tlb_entry_t  e,
                                        input logic        wr,
                                        input logic        k0_unc);
      xlate_t      r;
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
      r   = '0;
      pfn = va[12] ? e.pfn1 : e.pfn0;
      c   = va[12] ? e.c1   : e.c0;
      d   = va[12] ? e.d1   : e.d0;
      v   = va[12] ? e.v1   : e.v0;
      if (va[31:29] == KSEG0) begin
         r.paddr    = {3'b000, va[28:0]};
         r.uncached = k0_unc;
      end else if (va[31:29] == KSEG1) begin
         r.paddr    = {3'b000, va[28:0]};
         r.uncached = 1'b1;
      end else if (!hit) begin
         r.miss = 1'b1;
      end else if (!v) begin
         r.invalid = 1'b1;
      end else if (wr && !d) begin
         r.modified = 1'b1;
      end else begin
         r.paddr    = {pfn, va[11:0]};
         r.uncached = (c == CACHE_UNCACHED);
      end
      return r;
   endfunction

endpackage

// File: rtl/mmu_tlb_match.sv
// tlb_match: combinational fully-associative compare.
//   entries : all TLB entries (present bit already qualified)
//   vpn2    : va[31:13] to look up
//   asid    : ASID to compare, zero-extended to 8 bits
//   hit     : at least one entry matched
//   idx     : lowest matching index (0 when no hit)
module tlb_match
   import mmu_pkg::*;
#(
   parameter int TLB_ENTRIES = 8,
   localparam int IDX_W = $clog2(TLB_ENTRIES)
) (
   input  tlb_entry_t [TLB_ENTRIES-1:0] entries,
   input  logic [18:0]                  vpn2,
   input  logic [7:0]                   asid,
   output logic                         hit,
   output logic [IDX_W-1:0]             idx
);

   logic [TLB_ENTRIES-1:0] match;

   for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_match
      assign match[gi] = entries[gi].present &&
                         (entries[gi].vpn2 == vpn2) &&
                         (entries[gi].g || (entries[gi].asid == asid));
   end

   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

   // Page payload fields are carried in the entry but not needed here.
   logic unused_payload;
   assign unused_payload = ^entries;

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: MIPS-style translator. kseg0/kseg1 direct-mapped; other segments
// go through a fully-associative TLB of even/odd 4 KB page pairs.
//   inst_*  : instruction lookup port (req -> valid one cycle later)
//   data_*  : data lookup port, adds store-to-clean (modified) detection
//   tlb_we / tlb_windex / entry*_in : TLBWI
//   tlbr_*  / tlb_rindex / entry*_out : TLBR
//   tlbp_*  : TLBP probe on entryhi_in
// All results registered; result fields hold when no request was made.
module mmu_tlb
   import mmu_pkg::*;
#(
   parameter int TLB_ENTRIES = 8,
   parameter int ASID_W      = 8
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           inst_req,
   input  logic [31:0]                    inst_vaddr,
   output logic                           inst_valid,
   output logic [31:0]                    inst_paddr,
   output logic                           inst_uncached,
   output logic                           inst_miss,
   output logic                           inst_invalid,
   input  logic                           data_req,
   input  logic [31:0]                    data_vaddr,
   input  logic                           data_wr,
   output logic                           data_valid,
   output logic [31:0]                    data_paddr,
   output logic                           data_uncached,
   output logic                           data_miss,
   output logic                           data_invalid,
   output logic                           data_modified,
   input  logic [ASID_W-1:0]              cur_asid,
   input  logic                           k0_uncached,
   input  logic                           tlb_we,
   input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_windex,
   input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_rindex,
   input  logic [31:0]                    entryhi_in,
   input  logic [31:0]                    entrylo0_in,
   input  logic [31:0]                    entrylo1_in,
   input  logic                           tlbr_req,
   output logic                           tlbr_valid,
   output logic [31:0]                    entryhi_out,
   output logic [31:0]                    entrylo0_out,
   output logic [31:0]                    entrylo1_out,
   input  logic                           tlbp_req,
   output logic                           tlbp_valid,
   output logic                           tlbp_found,
   output logic [$clog2(TLB_ENTRIES)-1:0] tlbp_index
);

   localparam int IDX_W = $clog2(TLB_ENTRIES);

   // Entry payload (no reset) and present bits (reset) are kept apart.
   tlb_entry_t [TLB_ENTRIES-1:0] ent_q;
   logic       [TLB_ENTRIES-1:0] present_q;
   tlb_entry_t [TLB_ENTRIES-1:0] ent_view;
   tlb_entry_t                   wr_ent;

   always_comb begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         ent_view[i]         = ent_q[i];
         ent_view[i].present = ent_q[i].present & present_q[i];
      end
   end

   always_comb begin
      wr_ent         = '0;
      wr_ent.vpn2    = entryhi_in[VPN2_HI:VPN2_LO];
      wr_ent.asid    = 8'(entryhi_in[ASID_W-1:0]);
      wr_ent.g       = entrylo0_in[LO_G] & entrylo1_in[LO_G];
      wr_ent.present = 1'b1;
      wr_ent.pfn0    = entrylo0_in[LO_PFN_HI:LO_PFN_LO];
      wr_ent.c0      = entrylo0_in[LO_C_HI:LO_C_LO];
      wr_ent.d0      = entrylo0_in[LO_D];
      wr_ent.v0      = entrylo0_in[LO_V];
      wr_ent.pfn1    = entrylo1_in[LO_PFN_HI:LO_PFN_LO];
      wr_ent.c1      = entrylo1_in[LO_C_HI:LO_C_LO];
      wr_ent.d1      = entrylo1_in[LO_D];
      wr_ent.v1      = entrylo1_in[LO_V];
   end

   always_ff @(posedge clk) begin
      if (tlb_we) begin
         ent_q[tlb_windex] <= wr_ent;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         present_q <= '0;
      end else if (tlb_we) begin
         present_q[tlb_windex] <= 1'b1;
      end
   end

   // Three independent associative searches over the same array.
   logic             inst_hit, data_hit, probe_hit;
   logic [IDX_W-1:0] inst_idx, data_idx, probe_idx;

   tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_match_inst (
      .entries (ent_view),
      .vpn2    (inst_vaddr[VPN2_HI:VPN2_LO]),
      .asid    (8'(cur_asid)),
      .hit     (inst_hit),
      .idx     (inst_idx)
   );

   tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_match_data (
      .entries (ent_view),
      .vpn2    (data_vaddr[VPN2_HI:VPN2_LO]),
      .asid    (8'(cur_asid)),
      .hit     (data_hit),
      .idx     (data_idx)
   );

   tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_match_probe (
      .entries (ent_view),
      .vpn2    (entryhi_in[VPN2_HI:VPN2_LO]),
      .asid    (8'(entryhi_in[ASID_W-1:0])),
      .hit     (probe_hit),
      .idx     (probe_idx)
   );

   xlate_t inst_res_d, data_res_d, inst_res_q, data_res_q;

   assign inst_res_d = translate(inst_vaddr, inst_hit, ent_view[inst_idx], 1'b0, k0_uncached);
   assign data_res_d = translate(data_vaddr, data_hit, ent_view[data_idx], data_wr, k0_uncached);

   // TLBR: re-pack the stored entry; a non-present slot reads as all zeros.
   tlb_entry_t  rd_ent;
   logic [31:0] tlbr_hi_d, tlbr_lo0_d, tlbr_lo1_d;

   always_comb begin
      rd_ent     = ent_view[tlb_rindex];
      tlbr_hi_d  = '0;
      tlbr_lo0_d = '0;
      tlbr_lo1_d = '0;
      if (rd_ent.present) begin
         tlbr_hi_d[VPN2_HI:VPN2_LO]     = rd_ent.vpn2;
         tlbr_hi_d[7:0]                 = rd_ent.asid;
         tlbr_lo0_d[LO_PFN_HI:LO_PFN_LO] = rd_ent.pfn0;
         tlbr_lo0_d[LO_C_HI:LO_C_LO]     = rd_ent.c0;
         tlbr_lo0_d[LO_D]                = rd_ent.d0;
         tlbr_lo0_d[LO_V]                = rd_ent.v0;
         tlbr_lo0_d[LO_G]                = rd_ent.g;
         tlbr_lo1_d[LO_PFN_HI:LO_PFN_LO] = rd_ent.pfn1;
         tlbr_lo1_d[LO_C_HI:LO_C_LO]     = rd_ent.c1;
         tlbr_lo1_d[LO_D]                = rd_ent.d1;
         tlbr_lo1_d[LO_V]                = rd_ent.v1;
         tlbr_lo1_d[LO_G]                = rd_ent.g;
      end
   end

   logic             inst_valid_q, data_valid_q, tlbr_valid_q, tlbp_valid_q;
   logic [31:0]      tlbr_hi_q, tlbr_lo0_q, tlbr_lo1_q;
   logic             tlbp_found_q;
   logic [IDX_W-1:0] tlbp_index_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_valid_q <= 1'b0;
         data_valid_q <= 1'b0;
         tlbr_valid_q <= 1'b0;
         tlbp_valid_q <= 1'b0;
         inst_res_q   <= '0;
         data_res_q   <= '0;
         tlbr_hi_q    <= '0;
         tlbr_lo0_q   <= '0;
         tlbr_lo1_q   <= '0;
         tlbp_found_q <= 1'b0;
         tlbp_index_q <= '0;
      end else begin
         inst_valid_q <= inst_req;
         data_valid_q <= data_req;
         tlbr_valid_q <= tlbr_req;
         tlbp_valid_q <= tlbp_req;
         if (inst_req) inst_res_q <= inst_res_d;
         if (data_req) data_res_q <= data_res_d;
         if (tlbr_req) begin
            tlbr_hi_q  <= tlbr_hi_d;
            tlbr_lo0_q <= tlbr_lo0_d;
            tlbr_lo1_q <= tlbr_lo1_d;
         end
         if (tlbp_req) begin
            tlbp_found_q <= probe_hit;
            tlbp_index_q <= probe_hit ? probe_idx : '0;
         end
      end
   end

   assign inst_valid    = inst_valid_q;
   assign inst_paddr    = inst_res_q.paddr;
   assign inst_uncached = inst_res_q.uncached;
   assign inst_miss     = inst_res_q.miss;
   assign inst_invalid  = inst_res_q.invalid;
   assign data_valid    = data_valid_q;
   assign data_paddr    = data_res_q.paddr;
   assign data_uncached = data_res_q.uncached;
   assign data_miss     = data_res_q.miss;
   assign data_invalid  = data_res_q.invalid;
   assign data_modified = data_res_q.modified;
   assign tlbr_valid    = tlbr_valid_q;
   assign entryhi_out   = tlbr_hi_q;
   assign entrylo0_out  = tlbr_lo0_q;
   assign entrylo1_out  = tlbr_lo1_q;
   assign tlbp_valid    = tlbp_valid_q;
   assign tlbp_found    = tlbp_found_q;
   assign tlbp_index    = tlbp_index_q;

   // Reserved EntryHi/EntryLo bits are ignored; instruction fetches never
   // raise the store-to-clean exception.
   logic unused_bits;
   assign unused_bits = ^{entryhi_in[12:ASID_W], entrylo0_in[31:26],
                          entrylo1_in[31:26], inst_res_q.modified};

endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Parametrised successor to the fixed-segment address translator.
- kseg0/kseg1 remain direct-mapped. kuseg/kseg2/kseg3 are translated through a fully-associative, MIPS-style TLB with even/odd 4 KB page pairs.
- Serves one instruction port and one data port, plus CP0 TLBWI/TLBR/TLBP support.
- Sits between the CPU fetch/mem stages and the cache/bridge layer. Results are registered, with 1-cycle latency.

Parameters:
- TLB_ENTRIES, 8, number of entries; power of 2, range 2..32. Index width IDX_W = clog2(TLB_ENTRIES) is derived internally.
- ASID_W, 8, ASID width; valid range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  instruction lookup request this cycle.
- inst_vaddr  in  32  instruction virtual address.
- inst_valid  out  1  instruction result valid; asserted the cycle after inst_req.
- inst_paddr  out  32  instruction physical address.
- inst_uncached  out  1  instruction access bypasses cache.
- inst_miss  out  1  instruction TLB refill exception.
- inst_invalid  out  1  instruction hit on entry with V=0.
- data_req  in  1  data lookup request.
- data_vaddr  in  32  data virtual address.
- data_wr  in  1  data access is a store.
- data_valid  out  1  data result valid.
- data_paddr  out  32  data physical address.
- data_uncached  out  1  data access bypasses cache.
- data_miss  out  1  data TLB refill exception.
- data_invalid  out  1  data hit on entry with V=0.
- data_modified  out  1  store hit on entry with D=0.
- cur_asid  in  ASID_W  current ASID (CP0 EntryHi.ASID).
- k0_uncached  in  1  1 = kseg0 uncached (CP0 Config.K0 == 2).
- tlb_we  in  1  TLBWI write strobe.
- tlb_windex  in  IDX_W  TLB write index.
- tlb_rindex  in  IDX_W  TLB read index for TLBR; also the TLBP result index width.
- entryhi_in  in  32  EntryHi format: VPN2[31:13], ASID[ASID_W-1:0].
- entrylo0_in  in  32  even-page EntryLo: PFN[25:6], C[5:3], D[2], V[1], G[0].
- entrylo1_in  in  32  odd-page EntryLo, same format as entrylo0_in.
- tlbr_req  in  1  TLBR request.
- tlbr_valid  out  1  TLBR result valid.
- entryhi_out  out  32  TLBR EntryHi result.
- entrylo0_out  out  32  TLBR even-page EntryLo result.
- entrylo1_out  out  32  TLBR odd-page EntryLo result.
- tlbp_req  in  1  TLBP probe request; uses entryhi_in.
- tlbp_valid  out  1  TLBP result valid.
- tlbp_found  out  1  TLBP matched an entry.
- tlbp_index  out  IDX_W  TLBP matching index.

Behaviour:

Reset
- All outputs reset to 0.
- Every entry's internal present bit is cleared; a non-present entry never matches.
- Entry payload is not reset.
- Reset asserted mid-operation drops any pending result; *_valid is 0 on the first cycle after reset release.

Latency and handshake
- All ports (inst, data, TLBR, TLBP) are independent and fully pipelined.
- req in cycle N produces valid=1 in cycle N+1, for exactly 1 cycle, with all result fields registered.
- With req=0, valid=0 next cycle; result fields hold their previous values.

Segment decode on vaddr[31:29]
- 100 (kseg0): paddr = {3'b000, va[28:0]}; uncached = k0_uncached; no TLB lookup.
- 101 (kseg1): paddr = {3'b000, va[28:0]}; uncached = 1; no TLB lookup.
- All other segments are mapped.

Mapped lookup
- Entry i matches when present[i], VPN2[i] == va[31:13], and (G[i] or ASID[i] == cur_asid).
- Multiple matches: the lowest index wins. No machine-check exception.
- va[12] selects lo1 (1) or lo0 (0).
- On hit: paddr = {PFN[19:0], va[11:0]}; uncached = (C == 3'd2).
- Exception outputs are mutually exclusive, in this priority:
  - miss: no match.
  - invalid: match with V=0.
  - modified: data_wr=1 and D=0 (data port only).
- On any exception, paddr = 0 and uncached = 0.

TLBWI
- tlb_we in cycle N writes entry tlb_windex at the edge.
- The entry's G bit is stored as entrylo0_in.G & entrylo1_in.G.
- present is set to 1.
- Lookups, TLBP and TLBR issued in cycle N see the old contents; from cycle N+1 on they see the new contents.
- Write and lookup of the same entry in one cycle is legal and resolves to old contents.

TLBR
- Returns the stored fields in the input formats. Unused bits are 0.
- Both EntryLo G fields return the stored G.
- A non-present entry returns all zeros.

TLBP
- Uses entryhi_in VPN2/ASID with the same match and priority rules as lookup.
- tlbp_found = 0 forces tlbp_index = 0.

Decomposition:
- Shared package mmu_pkg holds:
  - EntryLo/EntryHi field position constants.
  - CACHE_UNCACHED = 3'd2.
  - Segment codes KSEG0 = 3'b100, KSEG1 = 3'b101.
  - Packed tlb_entry_t: vpn2, asid, g, present, pfn0, c0, d0, v0, pfn1, c1, d1, v1.
- Sub-module tlb_match: combinational, taking the entry array, vpn2 and asid, producing hit and the lowest hit index.
- tlb_match is instantiated three times: inst lookup, data lookup, TLBP.

Test Plan:
- Unmapped segments:
  - inst_req, va=0x9FC0_0100, k0_uncached=0 -> next cycle inst_valid=1, paddr=0x1FC0_0100, uncached=0.
  - data_req, va=0xBFAF_F000 -> paddr=0x1FAF_F000, uncached=1.
- Refill after reset: data_req, va=0x0040_0000 -> data_miss=1, paddr=0.
- Write then lookup:
  - TLBWI idx 3, EntryHi=0x0040_0005, lo0 PFN=0x12345, C=3, D=1, V=1, G=0; cur_asid=5.
  - Next cycle, va=0x0040_0ABC -> paddr=0x1234_5ABC, uncached=0.
  - Same va with cur_asid=6 -> data_miss=1.
- Odd page and exception priority:
  - lo1 with V=0 -> va=0x0040_1000 gives data_invalid=1.
  - lo0 with D=0, data_wr=1 -> data_modified=1 only.
- Same-cycle write, global match, TLBP/TLBR:
  - tlb_we and a lookup of the same VPN in the same cycle -> old result (miss); a lookup one cycle later -> hit.
  - Two global entries at idx 1 and 5 with the same VPN2 -> TLBP found=1, index=1.
  - TLBR idx 5 returns the written fields.
- Reset mid-request: deassert resetn in the cycle after inst_req -> inst_valid=0 while in reset and on the first cycle after release; a prior TLB entry misses.
